// File: rtl/siggen_pkg.sv
// siggen_pkg: shared types, sine table and scaling for multi_voice_generator.
// The sine table is a 128-entry raised-cosine-shaped unsigned curve.
package siggen_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'd0,
        SQUARE = 2'd1,
        TRI    = 2'd2,
        SAW    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    localparam int SINE_DEPTH = 128;

    localparam logic [7:0] SINE_TABLE [0:SINE_DEPTH-1] = '{
        8'd0,   8'd0,   8'd1,   8'd1,   8'd2,   8'd3,   8'd5,   8'd7,
        8'd10,  8'd13,  8'd17,  8'd21,  8'd25,  8'd29,  8'd34,  8'd39,
        8'd44,  8'd49,  8'd54,  8'd59,  8'd64,  8'd69,  8'd74,  8'd79,
        8'd84,  8'd89,  8'd94,  8'd99,  8'd104, 8'd110, 8'd116, 8'd122,
        8'd128, 8'd134, 8'd140, 8'd146, 8'd152, 8'd157, 8'd162, 8'd167,
        8'd172, 8'd177, 8'd182, 8'd187, 8'd192, 8'd197, 8'd202, 8'd207,
        8'd212, 8'd217, 8'd222, 8'd227, 8'd231, 8'd235, 8'd239, 8'd243,
        8'd246, 8'd249, 8'd251, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255,
        8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd253, 8'd251, 8'd249,
        8'd246, 8'd243, 8'd239, 8'd235, 8'd231, 8'd227, 8'd222, 8'd217,
        8'd212, 8'd207, 8'd202, 8'd197, 8'd192, 8'd187, 8'd182, 8'd177,
        8'd172, 8'd167, 8'd162, 8'd157, 8'd152, 8'd146, 8'd140, 8'd134,
        8'd128, 8'd122, 8'd116, 8'd110, 8'd104, 8'd99,  8'd94,  8'd89,
        8'd84,  8'd79,  8'd74,  8'd69,  8'd64,  8'd59,  8'd54,  8'd49,
        8'd44,  8'd39,  8'd34,  8'd29,  8'd25,  8'd21,  8'd17,  8'd13,
        8'd10,  8'd7,   8'd5,   8'd3,   8'd2,   8'd1,   8'd1,   8'd0
    };

    // Rounded wave*env/255; the product plus bias tops out at 65152.
    function automatic logic [7:0] scale_sample(
        input logic [7:0] wave,
        input logic [7:0] env
    );
        logic [15:0] prod;
        prod = 16'(wave) * 16'(env) + 16'd127;
        return 8'(prod / 16'd255);
    endfunction

endpackage

// File: rtl/multi_voice_generator_voice.sv
// voice_channel: one voice -- phase accumulator, gate FSM, envelope,
// waveform lookup and scaling. Define AMP_SMOOTH_EN for a ramped envelope.
module voice_channel
    import siggen_pkg::*;
#(
    parameter int SAMPLE_RATE = 32000,
    parameter int TABLE_DEPTH = 128,
    parameter int MAX_FREQ    = 8000,
    parameter int RAMP_DIV    = 100
) (
    input  logic        CLK_32KHz,
    input  logic        reset_n,
    input  logic [13:0] i_freq,
    input  logic [7:0]  i_amp,
    input  logic [1:0]  i_wave,
    input  logic [7:0]  i_offset,
    input  logic        i_gate,
    output logic [7:0]  o_sample,
    output logic        o_active,
    output logic        o_wrap
);
    localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int SH_R  = (IDX_W > 7) ? IDX_W - 7 : 0;
    localparam int SH_L  = (IDX_W < 7) ? 7 - IDX_W : 0;
    localparam logic [15:0] SR   = 16'(SAMPLE_RATE);
    localparam logic [15:0] FMAX =
        (MAX_FREQ > 16383) ? 16'd16383 : 16'(MAX_FREQ);

    voice_state_t r_state, w_state_nx;
    logic [15:0]  r_phase, w_phase_nx;
    logic [7:0]   r_env;
    logic         r_gate_q;
    logic [7:0]   r_sample;
    logic         r_wrap, w_wrap_nx;

    logic        w_rise, w_fall, w_wraps;
    logic [15:0] w_f, w_load, w_adv;
    logic [16:0] w_sum;
    logic [31:0] w_idx;
    logic [6:0]  w_n, w_dn;
    logic [8:0]  w_tri_raw;
    logic [7:0]  w_wave, w_target;

    assign w_rise   = i_gate & ~r_gate_q;
    assign w_fall   = ~i_gate & r_gate_q;
    assign w_target = i_gate ? i_amp : 8'd0;

    assign w_f     = (16'(i_freq) > FMAX) ? FMAX : 16'(i_freq);
    assign w_sum   = {1'b0, r_phase} + {1'b0, w_f};
    assign w_wraps = (w_f != 16'd0) && (w_sum >= {1'b0, SR});
    assign w_adv   = w_wraps ? 16'(w_sum - {1'b0, SR}) : w_sum[15:0];
    assign w_load  = 16'((32'(i_offset) * 32'(SAMPLE_RATE / 256))
                         % 32'(SAMPLE_RATE));

    // Table index, normalised to the 7-bit 128-step waveform domain
    assign w_idx = (32'(r_phase) * 32'(TABLE_DEPTH)) / 32'(SAMPLE_RATE);
    assign w_n   = 7'((w_idx >> SH_R) << SH_L);

    // Waveform lookup for the current phase
    always_comb begin
        w_dn      = 7'(8'd128 - {1'b0, w_n});
        w_tri_raw = w_n[6] ? {w_dn, 2'b00} : {1'b0, w_n[5:0], 2'b00};
        w_wave    = 8'd0;
        unique case (wave_t'(i_wave))
            SINE:    w_wave = SINE_TABLE[w_n];
            SQUARE:  w_wave = w_n[6] ? 8'd0 : 8'd255;
            TRI:     w_wave = w_tri_raw[8] ? 8'd255 : w_tri_raw[7:0];
            SAW:     w_wave = {w_n, 1'b0};
            default: w_wave = 8'd0;
        endcase
    end

    // Next state, phase and wrap; a gate rising edge wins from any state
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_wrap_nx  = 1'b0;
        if (w_rise) begin
            w_state_nx = RUN;
            w_phase_nx = w_load;
        end else begin
            if (r_state != IDLE) begin
                w_phase_nx = w_adv;
                w_wrap_nx  = w_wraps;
            end
            unique case (r_state)
                IDLE:    w_state_nx = IDLE;
                RUN:     if (w_fall) w_state_nx = RELEASE;
                RELEASE: if (r_env == 8'd0) w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // State, phase, gate history and registered outputs
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_phase  <= 16'd0;
            r_gate_q <= 1'b0;
            r_wrap   <= 1'b0;
            r_sample <= 8'd0;
        end else begin
            r_state  <= w_state_nx;
            r_phase  <= w_phase_nx;
            r_gate_q <= i_gate;
            r_wrap   <= w_wrap_nx;
            r_sample <= (r_state == IDLE) ? 8'd0
                                          : scale_sample(w_wave, r_env);
        end
    end

`ifdef AMP_SMOOTH_EN
    localparam int RW = (RAMP_DIV > 0) ? $clog2(RAMP_DIV + 1) : 1;
    logic [RW-1:0] r_ramp;
    logic          w_step;

    assign w_step = (r_ramp == RW'(RAMP_DIV));

    // Slew env one LSB toward the gate target every RAMP_DIV+1 clocks
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_ramp <= '0;
            r_env  <= 8'd0;
        end else if (w_step) begin
            r_ramp <= '0;
            if (r_env < w_target)
                r_env <= r_env + 8'd1;
            else if (r_env > w_target)
                r_env <= r_env - 8'd1;
        end else begin
            r_ramp <= r_ramp + 1'b1;
        end
    end
`else
    // Env jumps straight to the gate target
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n)
            r_env <= 8'd0;
        else
            r_env <= w_target;
    end
`endif

    assign o_sample = r_sample;
    assign o_active = (r_state != IDLE);
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/multi_voice_generator.sv
// multi_voice_generator: NUM_CH tone voices plus a registered average mix.
// Define AMP_SMOOTH_EN to ramp voice envelopes instead of stepping them.
module multi_voice_generator
    import siggen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_RATE = 32000,
    parameter int TABLE_DEPTH = SINE_DEPTH,
    parameter int MAX_FREQ    = 8000,
    parameter int RAMP_DIV    = 100
) (
    input  logic                 CLK_32KHz,
    input  logic                 reset_n,
    input  logic [NUM_CH*14-1:0] i_ch_freq,
    input  logic [NUM_CH*8-1:0]  i_ch_amp,
    input  logic [NUM_CH*2-1:0]  i_ch_wave,
    input  logic [NUM_CH*8-1:0]  i_ch_offset,
    input  logic [NUM_CH-1:0]    i_ch_gate,
    output logic [NUM_CH*8-1:0]  o_ch_sample,
    output logic [NUM_CH-1:0]    o_ch_active,
    output logic [NUM_CH-1:0]    o_ch_wrap,
    output logic [7:0]           o_mix_sample
);
    localparam int SHIFT = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int SW    = 8 + SHIFT;

    logic [NUM_CH*8-1:0] w_samples;
    logic [SW-1:0]       w_sum;
    logic [7:0]          r_mix;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        voice_channel #(
            .SAMPLE_RATE (SAMPLE_RATE),
            .TABLE_DEPTH (TABLE_DEPTH),
            .MAX_FREQ    (MAX_FREQ),
            .RAMP_DIV    (RAMP_DIV)
        ) u_voice (
            .CLK_32KHz (CLK_32KHz),
            .reset_n   (reset_n),
            .i_freq    (i_ch_freq[g*14 +: 14]),
            .i_amp     (i_ch_amp[g*8 +: 8]),
            .i_wave    (i_ch_wave[g*2 +: 2]),
            .i_offset  (i_ch_offset[g*8 +: 8]),
            .i_gate    (i_ch_gate[g]),
            .o_sample  (w_samples[g*8 +: 8]),
            .o_active  (o_ch_active[g]),
            .o_wrap    (o_ch_wrap[g])
        );
    end

    // Unsigned sum of all voice samples
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_sum = w_sum + SW'(w_samples[i*8 +: 8]);
    end

    // Average by shifting; NUM_CH is a power of two
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n)
            r_mix <= 8'd0;
        else
            r_mix <= 8'(w_sum >> SHIFT);
    end

    assign o_ch_sample  = w_samples;
    assign o_mix_sample = r_mix;

endmodule
